data_memory_bytelane: RTL

//  Next-generation RV32 data memory: byte-addressed, 2**ADDR_WIDTH words x 32b,

---
 rtl/data_memory_bytelane.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane
//   RV32 data memory, 2**ADDR_WIDTH words x 32 bits, byte addressed.
//   Supports byte/half/word stores with lane enables and sign/zero-extended
//   loads. Misaligned, out-of-range and illegal-size requests are flagged on
//   rsp_err and never touch memory. Read latency is one cycle. After reset
//   the array is swept to zero one word per cycle, and req_ready stays low
//   until the sweep is done.
//
//   state    | meaning
//   ST_CLEAR | zeroing mem[clr_idx_q]; requests not accepted
//   ST_RUN   | serving one request per cycle
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write, req_funct3 store/load select and RV32 size/sign code
//   req_addr, req_wdata   byte address and store data
//   rsp_valid             one-cycle pulse, one cycle after accept
//   rsp_rdata, rsp_err    extended load data (0 for stores/errors), error flag
//   busy                  clear sweep in progress
module data_memory_bytelane #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_idx_q;
  logic [31:0]           mem [DEPTH];

  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  zero_q;      // response carries no load data
  logic [31:0]           rd_word_q;
  logic [1:0]            lane_q;
  logic [2:0]            funct3_q;

  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [31:0]           wdata_rep;
  logic [31:0]           sel_word;

  assign req_ready = (state_q == ST_RUN);
  assign busy      = (state_q == ST_CLEAR);
  // Gate with rst so a request presented on a reset edge is fully dropped.
  assign accept    = rst && req_valid && req_ready;
  assign widx      = req_addr[ADDR_WIDTH+1:2];
  assign lane      = req_addr[1:0];

  always_comb begin
    req_err   = |req_addr[31:ADDR_WIDTH+2];
    be        = 4'h0;
    wdata_rep = req_wdata;
    case (req_funct3)
      3'b000: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        if (lane[0]) req_err = 1'b1;
        be        = 4'b0011 << lane;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        if (lane != 2'b00) req_err = 1'b1;
        be = 4'hF;
      end
      3'b100: if (req_write) req_err = 1'b1;
      3'b101: if (req_write || lane[0]) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (&clr_idx_q) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q <= req_err;
        zero_q    <= req_err || req_write;
      end
    end
  end

  // Storage and load pipeline; no reset so this maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst && state_q == ST_CLEAR) begin
      mem[clr_idx_q] <= '0;
    end else if (accept && req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
    if (accept) begin
      rd_word_q <= mem[widx];
      lane_q    <= lane;
      funct3_q  <= req_funct3;
    end
  end

  always_comb begin
    sel_word  = rd_word_q >> {lane_q, 3'b000};
    rsp_rdata = rd_word_q;
    case (funct3_q)
      3'b000:  rsp_rdata = {{24{sel_word[7]}}, sel_word[7:0]};
      3'b001:  rsp_rdata = {{16{sel_word[15]}}, sel_word[15:0]};
      3'b100:  rsp_rdata = {24'h0, sel_word[7:0]};
      3'b101:  rsp_rdata = {16'h0, sel_word[15:0]};
      default: rsp_rdata = rd_word_q;
    endcase
    if (zero_q) rsp_rdata = '0;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule
